fifo_drain_arbiter: RTL and testbench

//  Drains NUM_REQ independent FIFO queues (fifo_v3 instances, non-fall-through) into one

---
 rtl/fifo_drain_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
//   Drains NUM_REQ independent non-fall-through FIFOs into a single registered
//   valid/ready output stage. Weighted round-robin: a FIFO that wins a free
//   arbitration keeps the grant for up to MAX_BURST consecutive pops, as long
//   as it stays non-empty. This block owns the pop of every attached FIFO.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   flush_i       synchronous flush of arbiter state and output register
//   fifo_empty_i  empty flag of each attached FIFO
//   fifo_data_i   head entry of each attached FIFO
//   fifo_pop_o    pop strobe to each FIFO (one-hot or zero, combinational)
//   valid_o       output register holds an entry
//   ready_i       consumer accepts the entry in the output register
//   data_o        output payload
//   idx_o         index of the FIFO that data_o came from
//
// Handshake: an entry transfers on every clock edge where valid_o and ready_i
// are both high. valid_o never drops and data_o/idx_o never change while
// valid_o is high and ready_i is low. A new entry may be loaded on the same
// edge that the current one transfers, giving one entry per cycle.

module fifo_drain_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned IdxW       = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic [NUM_REQ-1:0] fifo_empty_i,
    input  dtype               fifo_data_i [NUM_REQ],
    output logic [NUM_REQ-1:0] fifo_pop_o,
    output logic               valid_o,
    input  logic               ready_i,
    output dtype               data_o,
    output logic [IdxW-1:0]    idx_o
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    // Arbitration state: FREE means no current owner, OWNED means `owner`
    // holds the grant and has used `burst_cnt` pops of its budget.
    localparam logic [0:0] ST_FREE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]      state;
    logic [IdxW-1:0] owner;
    logic [CntW-1:0] burst_cnt;
    logic [IdxW-1:0] rr_ptr;

    logic            slot_free;
    logic            any_req;
    logic            pop_en;
    logic            owned_ok;
    logic            rr_found;
    logic [IdxW-1:0] rr_sel;
    logic [IdxW-1:0] rr_next;
    logic [IdxW-1:0] grant;

    // The output slot can take a new entry if it is empty or being drained
    // this very cycle.
    assign slot_free = ~valid_o | ready_i;
    assign any_req   = ~&fifo_empty_i;
    // rst_ni gates the pop so that no FIFO is popped while the arbiter is
    // held in reset (the output register could not capture the entry).
    assign pop_en    = rst_ni & slot_free & ~flush_i & any_req;

    assign owned_ok  = (state == ST_OWNED)
                     && (burst_cnt < CntW'(MAX_BURST))
                     && !fifo_empty_i[owner];

    // First non-empty FIFO at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned sum;
        logic [IdxW-1:0] cand;
        rr_sel   = '0;
        rr_found = 1'b0;
        sum      = 0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = 32'(rr_ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IdxW'(sum);
            if (!rr_found && !fifo_empty_i[cand]) begin
                rr_found = 1'b1;
                rr_sel   = cand;
            end
        end
    end

    assign rr_next = (rr_sel == IdxW'(NUM_REQ - 1)) ? '0 : rr_sel + 1'b1;
    assign grant   = owned_ok ? owner : rr_sel;

    always_comb begin
        fifo_pop_o = '0;
        if (pop_en) begin
            fifo_pop_o[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o   <= 1'b0;
            data_o    <= '0;
            idx_o     <= '0;
            state     <= ST_FREE;
            owner     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else if (flush_i) begin
            // Pending output entry is dropped; next grant searches from 0.
            valid_o   <= 1'b0;
            state     <= ST_FREE;
            owner     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else if (pop_en) begin
            valid_o <= 1'b1;
            data_o  <= fifo_data_i[grant];
            idx_o   <= grant;
            if (owned_ok) begin
                burst_cnt <= burst_cnt + 1'b1;
            end else begin
                state     <= ST_OWNED;
                owner     <= rr_sel;
                burst_cnt <= CntW'(1);
                rr_ptr    <= rr_next;
            end
        end else if (slot_free) begin
            // Nothing to pop with a free slot: the current entry (if any)
            // has transferred, and ownership lapses so the next pop is FREE.
            valid_o   <= 1'b0;
            state     <= ST_FREE;
            owner     <= '0;
            burst_cnt <= '0;
        end
        // Stall (valid_o & ~ready_i): everything holds.
    end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Testbench for fifo_drain_arbiter: FIFOs are modelled as queues in the bench,
// an independent reference model predicts each pop and pushes the expected
// output entry into a scoreboard queue, and a monitor pops and compares it on
// every output handshake.

module tb_fifo_drain_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int IW = 2;
    localparam int EW = IW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni;
    logic          flush;
    logic          ready;
    logic [NR-1:0] fifo_empty;
    logic [DW-1:0] fifo_data [NR];
    logic [NR-1:0] fifo_pop;
    logic          valid;
    logic [DW-1:0] data;
    logic [IW-1:0] idx;

    fifo_drain_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush),
        .fifo_empty_i(fifo_empty),
        .fifo_data_i (fifo_data),
        .fifo_pop_o  (fifo_pop),
        .valid_o     (valid),
        .ready_i     (ready),
        .data_o      (data),
        .idx_o       (idx)
    );

    // ---------------- bench state ----------------
    logic [DW-1:0] fifo_q [NR][$];
    logic [EW-1:0] exp_q[$];
    int            obs_q[$];
    logic [NR-1:0] pend_pop;
    int            n_pass;
    int            n_total;
    int            seq;

    // reference model state
    bit m_valid;
    int m_owner;
    int m_cnt;
    int m_ptr;
    int wait_cnt [NR];

    int t2_exp [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    int t3_exp [8] = '{3, 3, 1, 1, 0, 0, 0, 0};
    int t4_exp [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    int t5_exp [8] = '{0, 0, 2, 2, 0, 0, 0, 0};

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic refresh();
        for (int i = 0; i < NR; i++) begin
            fifo_empty[i] = (fifo_q[i].size() == 0);
            fifo_data[i]  = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
        end
    endtask

    task automatic push(input int s);
        fifo_q[s].push_back({8'(s), 24'(seq)});
        seq++;
        refresh();
    endtask

    // Advance one clock; the FIFOs apply the pop seen before the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (pend_pop[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
        end
        refresh();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    function automatic bit all_idle();
        bit e;
        e = !valid;
        for (int i = 0; i < NR; i++) if (fifo_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        ready = 1'b1;
        flush = 1'b0;
        while (!all_idle() && n < 3000) begin
            cycle();
            n++;
        end
        check(all_idle(), name, 64'(n), 64'(0));
    endtask

    task automatic check_seq(input string name, input int expa [8], input int n);
        check(obs_q.size() == n, {name, "_len"}, 64'(obs_q.size()), 64'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            check(obs_q[i] == expa[i], $sformatf("%s_idx%0d", name, i),
                  64'(obs_q[i]), 64'(expa[i]));
        end
    endtask

    // ---------------- reference model ----------------
    always @(negedge clk) begin : model
        logic [NR-1:0] ne;
        logic [NR-1:0] exp_mask;
        int            g;
        bit            sf;
        int            maxw;
        if (!rst_ni) begin
            m_valid = 1'b0;
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 0;
            exp_q.delete();
            pend_pop = '0;
            for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
            check(!valid && fifo_pop == '0, "reset_out", 64'({valid, fifo_pop}), 64'(0));
        end else begin
            check(valid == m_valid, "valid", 64'(valid), 64'(m_valid));
            for (int i = 0; i < NR; i++) ne[i] = (fifo_q[i].size() != 0);
            check((fifo_pop & ~ne) == '0, "pop_legal", 64'(fifo_pop), 64'(ne));
            sf = !m_valid || ready;
            g  = -1;
            if (!flush && sf && ne != '0) begin
                if (m_owner >= 0 && m_cnt < MB && ne[m_owner]) begin
                    g = m_owner;
                    m_cnt++;
                end else begin
                    for (int k = 0; k < NR; k++) begin
                        if (ne[(m_ptr + k) % NR]) begin
                            g = (m_ptr + k) % NR;
                            break;
                        end
                    end
                    m_owner = g;
                    m_cnt   = 1;
                    m_ptr   = (g + 1) % NR;
                end
            end
            exp_mask = (g >= 0) ? (NR'(1) << g) : '0;
            check(fifo_pop == exp_mask, "pop_sel", 64'(fifo_pop), 64'(exp_mask));
            pend_pop = fifo_pop;
            if (flush) begin
                m_valid = 1'b0;
                m_owner = -1;
                m_cnt   = 0;
                m_ptr   = 0;
                exp_q.delete();
                for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
            end else if (g >= 0) begin
                exp_q.push_back({IW'(g), fifo_q[g][0]});
                m_valid = 1'b1;
                maxw = 0;
                for (int i = 0; i < NR; i++) begin
                    if (i == g || !ne[i]) wait_cnt[i] = 0;
                    else wait_cnt[i]++;
                    if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
                end
                check(maxw <= NR * MB, "fairness", 64'(maxw), 64'(NR * MB));
            end else if (sf) begin
                m_valid = 1'b0;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        if (rst_ni && valid && ready && !flush) begin
            obs_q.push_back(int'(idx));
            if (exp_q.size() == 0) begin
                check(1'b0, "spurious_out", 64'({idx, data}), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check({idx, data} == e, "out_entry", 64'({idx, data}), 64'(e));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d0;
        n_pass   = 0;
        n_total  = 0;
        seq      = 0;
        pend_pop = '0;
        rst_ni   = 1'b0;
        ready    = 1'b0;
        flush    = 1'b0;
        refresh();

        // Reset: outputs idle and no pop even with FIFO0 holding data.
        push(0);
        @(negedge clk);
        check(fifo_pop == '0, "rst_pop", 64'(fifo_pop), 64'(0));
        check(!valid, "rst_valid", 64'(valid), 64'(0));
        check(data == '0, "rst_data", 64'(data), 64'(0));
        check(idx == '0, "rst_idx", 64'(idx), 64'(0));
        cycle();
        rst_ni = 1'b1;
        ready  = 1'b1;
        @(negedge clk);
        check(fifo_pop == 4'b0001, "t1_pop0", 64'(fifo_pop), 64'(1));
        cycle();
        @(negedge clk);
        check(valid == 1'b1, "t1_valid", 64'(valid), 64'(1));
        check(idx == 2'd0, "t1_idx", 64'(idx), 64'(0));
        run(3);

        // Return rr pointer to 0 before the burst test.
        flush = 1'b1;
        cycle();
        flush = 1'b0;

        // Burst budget: FIFO0 x6, FIFO1 x2.
        obs_q.delete();
        for (int i = 0; i < 6; i++) push(0);
        push(1);
        push(1);
        run(12);
        check_seq("t2", t2_exp, 8);

        // Wrap: move rr pointer to 3 via a single FIFO2 grant, then 3 and 1.
        push(2);
        run(4);
        obs_q.delete();
        push(3);
        push(3);
        push(1);
        push(1);
        run(8);
        check_seq("t3", t3_exp, 4);

        // Backpressure: entry held for 5 cycles with no pops.
        ready = 1'b0;
        obs_q.delete();
        push(1);
        d0 = fifo_q[1][0];
        push(1);
        push(1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(valid == 1'b1, "t4_valid", 64'(valid), 64'(1));
            check(fifo_pop == '0, "t4_no_pop", 64'(fifo_pop), 64'(0));
            check(data == d0, "t4_data_stable", 64'(data), 64'(d0));
            cycle();
        end
        ready = 1'b1;
        run(6);
        check_seq("t4", t4_exp, 3);

        // Flush mid-burst: owner=2 with two pops used.
        for (int i = 0; i < 4; i++) push(2);
        cycle();
        cycle();
        flush = 1'b1;
        push(0);
        push(0);
        obs_q.delete();
        @(negedge clk);
        check(fifo_pop == '0, "t5_flush_no_pop", 64'(fifo_pop), 64'(0));
        cycle();
        flush = 1'b0;
        @(negedge clk);
        check(!valid, "t5_valid_clear", 64'(valid), 64'(0));
        check(fifo_pop == 4'b0001, "t5_restart_from_0", 64'(fifo_pop), 64'(1));
        run(8);
        check_seq("t5", t5_exp, 4);

        // Random pushes, ready and occasional flush.
        for (int c = 0; c < 2000; c++) begin
            cycle();
            if ($urandom_range(0, 99) < 30) push(0);
            if ($urandom_range(0, 99) < 20) push(1);
            if ($urandom_range(0, 99) < 10) push(2);
            if ($urandom_range(0, 99) < 10) push(3);
            ready = ($urandom_range(0, 99) < 75);
            flush = ($urandom_range(0, 99) < 1);
        end
        drain("random_drain");

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 6; i++) push(0);
        run(2);
        #2;
        rst_ni = 1'b0;
        #1;
        check(!valid, "ar_valid", 64'(valid), 64'(0));
        check(fifo_pop == '0, "ar_pop", 64'(fifo_pop), 64'(0));
        check(data == '0, "ar_data", 64'(data), 64'(0));
        cycle();
        cycle();
        rst_ni = 1'b1;
        drain("ar_drain");
        check(exp_q.size() == 0, "final_sb_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
